// File: rtl/sonar_sequenciador.sv
// Sweep scheduler for the sonar: servo positioning, settling, one HC-SR04 measurement and a
// fixed-length serial report per position. Define SONAR_TIMEOUT_EN to add the measurement timeout.
module sonar_sequenciador #(
    parameter int N_POS          = 8,
    parameter int SETTLE_CYCLES  = 25_000_000,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int N_CHARS        = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       fim_medida,
    input  logic       fim_transmissao,
    output logic       medir,
    output logic       transmitir,
    output logic [2:0] posicao,
    output logic [2:0] indice_char,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        POSICIONA      = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_TX     = 4'd5,
        PROXIMA_POS    = 4'd6
    } estado_t;

    localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    POS_LAST    = 3'(N_POS - 1);
    localparam logic [2:0]    CHAR_LAST   = 3'(N_CHARS - 1);

    estado_t       estado;
    estado_t       estado_next;
    logic [SW-1:0] settle_cnt;
    logic [SW-1:0] settle_cnt_next;
    logic [2:0]    posicao_next;
    logic [2:0]    indice_char_next;
    logic          subindo;
    logic          subindo_next;
    logic          primeiro;
    logic          primeiro_next;

`ifdef SONAR_TIMEOUT_EN
    localparam int            TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timeout_cnt;
    logic [TW-1:0] timeout_cnt_next;
    logic          timeout_r;
    logic          timeout_next;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= INICIAL;
            settle_cnt  <= '0;
            posicao     <= '0;
            indice_char <= '0;
            subindo     <= 1'b1;
            primeiro    <= 1'b1;
        end else begin
            estado      <= estado_next;
            settle_cnt  <= settle_cnt_next;
            posicao     <= posicao_next;
            indice_char <= indice_char_next;
            subindo     <= subindo_next;
            primeiro    <= primeiro_next;
        end
    end

`ifdef SONAR_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_cnt <= '0;
            timeout_r   <= 1'b0;
        end else begin
            timeout_cnt <= timeout_cnt_next;
            timeout_r   <= timeout_next;
        end
    end
`endif

    always_comb begin
        estado_next      = estado;
        settle_cnt_next  = settle_cnt;
        posicao_next     = posicao;
        indice_char_next = indice_char;
        subindo_next     = subindo;
        primeiro_next    = primeiro;
`ifdef SONAR_TIMEOUT_EN
        timeout_cnt_next = timeout_cnt;
        timeout_next     = timeout_r;
`endif

        case (estado)
            INICIAL: begin
                if (ligar) begin
                    estado_next = POSICIONA;
                end
            end

            POSICIONA: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_next = '0;
                    estado_next     = MEDE;
                end else begin
                    settle_cnt_next = settle_cnt + 1'b1;
                end
            end

            MEDE: begin
`ifdef SONAR_TIMEOUT_EN
                timeout_next     = 1'b0;
                timeout_cnt_next = '0;
`endif
                estado_next = AGUARDA_MEDIDA;
            end

            // A real measurement arriving on the expiry cycle takes precedence over the timeout.
            AGUARDA_MEDIDA: begin
`ifdef SONAR_TIMEOUT_EN
                if (fim_medida) begin
                    timeout_cnt_next = '0;
                    estado_next      = TRANSMITE;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    timeout_cnt_next = '0;
                    timeout_next     = 1'b1;
                    estado_next      = TRANSMITE;
                end else begin
                    timeout_cnt_next = timeout_cnt + 1'b1;
                end
`else
                if (fim_medida) begin
                    estado_next = TRANSMITE;
                end
`endif
            end

            TRANSMITE: begin
                estado_next = AGUARDA_TX;
            end

            AGUARDA_TX: begin
                if (fim_transmissao) begin
                    if (indice_char == CHAR_LAST) begin
                        estado_next = PROXIMA_POS;
                    end else begin
                        indice_char_next = indice_char + 1'b1;
                        estado_next      = TRANSMITE;
                    end
                end
            end

            // Triangular sweep: each endpoint is visited once before the direction flips.
            PROXIMA_POS: begin
                indice_char_next = '0;
                primeiro_next    = 1'b0;
                if (!ligar) begin
                    posicao_next  = '0;
                    subindo_next  = 1'b1;
                    primeiro_next = 1'b1;
                    estado_next   = INICIAL;
                end else begin
                    estado_next = POSICIONA;
                    if (subindo) begin
                        if (posicao == POS_LAST) begin
                            posicao_next = posicao - 1'b1;
                            subindo_next = 1'b0;
                        end else begin
                            posicao_next = posicao + 1'b1;
                        end
                    end else begin
                        if (posicao == 3'd0) begin
                            posicao_next = posicao + 1'b1;
                            subindo_next = 1'b1;
                        end else begin
                            posicao_next = posicao - 1'b1;
                        end
                    end
                end
            end

            default: begin
                estado_next      = INICIAL;
                settle_cnt_next  = '0;
                posicao_next     = '0;
                indice_char_next = '0;
                subindo_next     = 1'b1;
                primeiro_next    = 1'b1;
`ifdef SONAR_TIMEOUT_EN
                timeout_cnt_next = '0;
                timeout_next     = 1'b0;
`endif
            end
        endcase
    end

    assign medir      = (estado == MEDE);
    assign transmitir = (estado == TRANSMITE);
    assign db_estado  = estado;
    assign pronto     = (estado == PROXIMA_POS) && !primeiro &&
                        ((posicao == 3'd0) || (posicao == POS_LAST));

`ifdef SONAR_TIMEOUT_EN
    assign timeout = timeout_r;
`else
    // Without the counter TIMEOUT_CYCLES is accepted but has no effect.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_ignored
    end
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sonar_sequenciador.sv
// Directed-random bench for sonar_sequenciador: sweep order, report sequencing, stop, reset
// and (when SONAR_TIMEOUT_EN is defined) the measurement timeout, against an arithmetic model.
`timescale 1ns/1ps
module tb_sonar_sequenciador;

    localparam int N_POS          = 4;
    localparam int SETTLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 20;
    localparam int N_CHARS        = 3;
`ifdef SONAR_TIMEOUT_EN
    localparam int TO_MODE = 1;
`else
    localparam int TO_MODE = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       fim_medida;
    logic       fim_transmissao;
    logic       medir;
    logic       transmitir;
    logic [2:0] posicao;
    logic [2:0] indice_char;
    logic       timeout;
    logic       pronto;
    logic [3:0] db_estado;

    int checks   = 0;
    int failures = 0;

    sonar_sequenciador #(
        .N_POS         (N_POS),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .N_CHARS       (N_CHARS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ligar          (ligar),
        .fim_medida     (fim_medida),
        .fim_transmissao(fim_transmissao),
        .medir          (medir),
        .transmitir     (transmitir),
        .posicao        (posicao),
        .indice_char    (indice_char),
        .timeout        (timeout),
        .pronto         (pronto),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    // Position of the k-th report since the sweep started: a triangle wave of period 2*(N_POS-1).
    function automatic int model_pos(input int k);
        int period;
        int m;
        period = 2 * (N_POS - 1);
        m      = k % period;
        return (m < N_POS) ? m : period - m;
    endfunction

    function automatic int model_pronto(input int k);
        int p;
        p = model_pos(k);
        return ((k > 0) && (p == 0 || p == N_POS - 1)) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick_with(input logic med, input logic tx);
        fim_medida      = med;
        fim_transmissao = tx;
        @(negedge clock);
        fim_medida      = 1'b0;
        fim_transmissao = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_estado"}, 32'(db_estado), 32'd0);
        check({tag, "_medir"}, 32'(medir), 32'd0);
        check({tag, "_transmitir"}, 32'(transmitir), 32'd0);
        check({tag, "_pronto"}, 32'(pronto), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_posicao"}, 32'(posicao), 32'd0);
        check({tag, "_indice"}, 32'(indice_char), 32'd0);
    endtask

    // Entered on the first POSICIONA cycle; leaves on the cycle after PROXIMA_POS.
    // mode 0: random fim_medida delay, 1: let the timeout expire, 2: fim_medida on the expiry cycle.
    task automatic run_report(input int k, input int mode, input bit drop);
        int   c;
        int   w;
        logic exp_to;
        check("posicao_report", 32'(posicao), 32'(model_pos(k)));
        c = 0;
        while (medir !== 1'b1 && c < SETTLE_CYCLES + 4) begin
            tick_with(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            c++;
        end
        check("settle_cycles", 32'(c), 32'(SETTLE_CYCLES));
        check("posicao_at_medir", 32'(posicao), 32'(model_pos(k)));
        tick_with(1'b0, 1'b0);
        check("estado_aguarda_medida", 32'(db_estado), 32'd3);
        check("medir_one_cycle", 32'(medir), 32'd0);
        check("timeout_cleared", 32'(timeout), 32'd0);
        exp_to = 1'b0;
        if (mode == 1) begin
`ifdef SONAR_TIMEOUT_EN
            c = 1;
            while (transmitir !== 1'b1 && c < TIMEOUT_CYCLES + 5) begin
                tick_with(1'b0, 1'($urandom_range(0, 1)));
                c++;
            end
            check("timeout_latency", 32'(c), 32'(TIMEOUT_CYCLES + 1));
            exp_to = 1'b1;
`endif
        end else begin
            w = (mode == 2) ? TIMEOUT_CYCLES - 1 : int'($urandom_range(0, 8));
            repeat (w) tick_with(1'b0, 1'($urandom_range(0, 1)));
            tick_with(1'b1, 1'b0);
            check("transmitir_after_fim_medida", 32'(transmitir), 32'd1);
        end
        for (int i = 0; i < N_CHARS; i++) begin
            if (i > 0) begin
                c = 0;
                while (transmitir !== 1'b1 && c < 4) begin
                    tick_with(1'b0, 1'b0);
                    c++;
                end
            end
            check("transmitir_char", 32'(transmitir), 32'd1);
            check("indice_char", 32'(indice_char), 32'(i));
            check("timeout_flag", 32'(timeout), 32'(exp_to));
            if (drop && i == 1) ligar = 1'b0;
            tick_with(1'b0, 1'b0);
            check("estado_aguarda_tx", 32'(db_estado), 32'd5);
            repeat ($urandom_range(0, 3)) tick_with(1'($urandom_range(0, 1)), 1'b0);
            tick_with(1'b0, 1'b1);
            if (i < N_CHARS - 1) check("indice_next", 32'(indice_char), 32'(i + 1));
        end
        check("estado_proxima_pos", 32'(db_estado), 32'd6);
        check("pronto", 32'(pronto), 32'(model_pronto(k)));
        tick_with(1'b0, 1'b0);
        check("pronto_one_cycle", 32'(pronto), 32'd0);
        check("indice_cleared", 32'(indice_char), 32'd0);
        if (drop) begin
            check("estado_stop", 32'(db_estado), 32'd0);
            check("posicao_stop", 32'(posicao), 32'd0);
        end else begin
            check("estado_posiciona", 32'(db_estado), 32'd1);
            check("posicao_next", 32'(posicao), 32'(model_pos(k + 1)));
        end
    endtask

    initial begin
        int c;
        reset           = 1'b1;
        ligar           = 1'b0;
        fim_medida      = 1'b0;
        fim_transmissao = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_values("reset");

        reset = 1'b0;
        repeat (3) tick_with(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("idle_without_ligar", 32'(db_estado), 32'd0);

        ligar = 1'b1;
        tick_with(1'b0, 1'b0);
        check("posiciona_after_one_edge", 32'(db_estado), 32'd1);
        for (int k = 0; k < 8; k++) begin
            run_report(k, (k == 2) ? 2 : ((k == 3) ? TO_MODE : 0), 1'b0);
        end
        run_report(8, 0, 1'b1);

        tick_with(1'b0, 1'b0);
        check("stays_idle", 32'(db_estado), 32'd0);
        ligar = 1'b1;
        tick_with(1'b0, 1'b0);
        check("restart_posiciona", 32'(db_estado), 32'd1);
        run_report(0, 0, 1'b0);

        c = 0;
        while (medir !== 1'b1 && c < SETTLE_CYCLES + 4) begin
            tick_with(1'b0, 1'b0);
            c++;
        end
        check("settle_restart", 32'(c), 32'(SETTLE_CYCLES));
        tick_with(1'b0, 1'b0);
`ifndef SONAR_TIMEOUT_EN
        repeat (1000) tick_with(1'b0, 1'b0);
        check("waits_without_timeout", 32'(db_estado), 32'd3);
        check("no_transmitir_while_waiting", 32'(transmitir), 32'd0);
`endif
        tick_with(1'b1, 1'b0);
        check("transmitir_before_reset", 32'(transmitir), 32'd1);
        tick_with(1'b0, 1'b0);
        check("estado_before_reset", 32'(db_estado), 32'd5);

        reset = 1'b1;
        ligar = 1'b0;
        tick_with(1'b0, 1'b1);
        check_reset_values("midop_reset");
        reset = 1'b0;
        tick_with(1'b0, 1'b1);
        check("stray_tx_after_reset", 32'(db_estado), 32'd0);
        check("stray_tx_indice", 32'(indice_char), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
